seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//   Sequential unsigned restoring divider. It is the inverse companion to the team's
//   combinational array/Dadda multipliers: given prod-style operands it recovers
//   quotient and remainder, one quotient bit per clock. It sits beside the multiplier
//   in the arithmetic datapath and uses a start/busy/done handshake.
// PARAMETERS
//   WIDTH   4   operand width in bits (dividend, divisor, quotient, remainder); legal >= 2
// PORTS
//   clk          in   1      single clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   start        in   1      request; sampled only while in IDLE
//   A            in   WIDTH  dividend, captured on accepted start
//   B            in   WIDTH  divisor, captured on accepted start
//   busy         out  1      high in CALC and DONE states
//   done         out  1      one-cycle pulse; results valid from this cycle on
//   quot         out  WIDTH  quotient, registered, held until next completion
//   rem          out  WIDTH  remainder, registered, held until next completion
//   div_by_zero  out  1      registered flag; updated together with quot/rem
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE; busy=0, done=0, quot=0, rem=0,
//     div_by_zero=0; internal R, Q, D and the step counter are cleared.
//   - FSM IDLE -> CALC -> DONE -> IDLE:
//     IDLE: on start=1, capture D=B, Q=A, R=0, cnt=WIDTH-1. Go to CALC, or go
//           directly to DONE if B==0.
//     CALC: one restoring step per cycle:
//           Rs = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits); diff = Rs - {1'b0,D}.
//           If diff[WIDTH]==0: R=diff, Q={Q[WIDTH-2:0],1}. Otherwise R=Rs, Q={Q[WIDTH-2:0],0}.
//           When cnt==0, go to DONE; otherwise cnt=cnt-1. CALC lasts exactly WIDTH cycles.
//     DONE: done=1 for this cycle only. quot/rem/div_by_zero are loaded on entry
//           so they are valid in this cycle. Next state is IDLE.
//   - Latency: if start is accepted at edge t, done is high in cycle t+WIDTH+1 (5 for
//     WIDTH=4). With B==0, done is high in cycle t+1.
//   - Divide by zero: quot = all ones, rem = A, div_by_zero = 1. No CALC cycles.
//   - Normal completion: div_by_zero = 0, quot = Q, rem = R[WIDTH-1:0].
//   - start while busy (CALC or DONE) is ignored; A and B are not re-sampled. An
//     operation in progress is never aborted except by rst.
//   - Back-to-back: start high in the IDLE cycle that follows DONE is accepted.
//     Minimum issue interval is WIDTH+2 cycles.
//   - A/B changes after acceptance have no effect; operands are held internally.
//   - Reset mid-operation: everything returns to reset values immediately. No done
//     pulse is issued for the aborted operation.
//   - Arithmetic: R is WIDTH+1 bits wide, so the subtract borrow is diff[WIDTH].
//     quot = floor(A/B), rem = A mod B, and rem < B always holds.
// STRUCTURE
//   - Shared include div_defs.vh: localparams for the state encoding
//     (S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2) and the default WIDTH.
//   - One combinational sub-module, div_step: inputs R, Q msb, D; outputs next R,
//     quotient bit. Its internal (WIDTH+1)-bit subtractor is a ripple chain of the
//     team's FullAdder cells (A + ~D + 1).
//   - Top level holds the FSM, cnt ($clog2(WIDTH) bits), and the R/Q/D and output
//     registers.
// TESTING
//   1. A=13, B=3, start one cycle -> done in cycle 5; quot=4, rem=1, div_by_zero=0;
//      busy high for cycles 1..5.
//   2. A=15, B=1 -> quot=15, rem=0.  A=2, B=9 -> quot=0, rem=2.  A=15, B=15 -> quot=1, rem=0.
//   3. A=7, B=0 -> done in cycle 1; quot=15, rem=7, div_by_zero=1. A following A=6, B=2
//      clears the flag: quot=3, rem=0.
//   4. start pulsed at cycle 2 of a busy operation with different A/B -> ignored;
//      original result returned, only one done pulse.
//   5. rst asserted mid-CALC (cycle 3) -> outputs 0 asynchronously, no done; a new
//      start after release gives a correct result.
//   6. Exhaustive sweep of all 256 A/B pairs, issued back-to-back at the minimum
//      interval -> each result matches A/B and A%B (B==0 rule as in 3); the
//      scoreboard checks done spacing of WIDTH+2 cycles.

Source files
------------

// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : seq_restoring_divider_pkg
//  Brief   : Shared state encoding and default width for the restoring divider
//  Revision: 1.0 - initial release
// ============================================================================
package seq_restoring_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider_fa.sv
`default_nettype none
// ============================================================================
//  Module  : FullAdder
//  Brief   : One-bit full adder cell used in ripple subtractor chains
//  Revision: 1.0 - initial release
// ============================================================================
module FullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider_step.sv
`default_nettype none
// ============================================================================
//  Module  : div_step
//  Brief   : One restoring-division step: shift in a dividend bit, trial
//            subtract the divisor, keep or restore the partial remainder
//  Revision: 1.0 - initial release
// ============================================================================
module div_step
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_r_next,
    output logic             o_q_bit
);

    logic [WIDTH:0]   w_rs;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_d_inv;

    assign w_rs       = {i_r, i_q_msb};
    assign w_d_inv    = ~i_d;
    assign w_carry[0] = 1'b1;

    // Rs + ~{0,D} + 1 as a ripple chain over the low WIDTH bits
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_sub_bit
            FullAdder u_fa (
                .i_a    (w_rs[i]),
                .i_b    (w_d_inv[i]),
                .i_cin  (w_carry[i]),
                .o_sum  (w_diff[i]),
                .o_cout (w_carry[i+1])
            );
        end
    endgenerate

    // Top (sign) bit: divisor's inverted msb is 1, and only the sum is needed
    assign w_diff[WIDTH] = w_rs[WIDTH] ^ 1'b1 ^ w_carry[WIDTH];

    // Non-negative difference -> quotient bit 1 and keep diff; else restore.
    // The restored/kept remainder is always below D, so WIDTH bits suffice.
    assign o_q_bit  = ~w_diff[WIDTH];
    assign o_r_next = o_q_bit ? w_diff[WIDTH-1:0] : w_rs[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module  : seq_restoring_divider
//  Brief   : Sequential unsigned restoring divider, one quotient bit per
//            clock, start/busy/done handshake, divide-by-zero flag
//  Revision: 1.0 - initial release
// ============================================================================
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_R;
    logic [WIDTH-1:0] r_Q;
    logic [WIDTH-1:0] r_D;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic [WIDTH-1:0] w_r_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_next;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_r      (r_R),
        .i_q_msb  (r_Q[WIDTH-1]),
        .i_d      (r_D),
        .o_r_next (w_r_next),
        .o_q_bit  (w_q_bit)
    );

    assign w_q_next = {r_Q[WIDTH-2:0], w_q_bit};

    // Next-state logic: zero divisor skips the iterative phase entirely
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (B == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture, iteration registers and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_R    <= '0;
            r_Q    <= '0;
            r_D    <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_D   <= B;
                        r_Q   <= A;
                        r_R   <= '0;
                        r_cnt <= CW'(WIDTH - 1);
                        if (B == '0) begin
                            r_quot <= '1;
                            r_rem  <= A;
                            r_dbz  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_R <= w_r_next;
                    r_Q <= w_q_next;
                    if (r_cnt == '0) begin
                        // Results land on entry to DONE so they are valid with done
                        r_quot <= w_q_next;
                        r_rem  <= w_r_next;
                        r_dbz  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign quot        = r_quot;
    assign rem         = r_rem;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module  : tb_seq_restoring_divider
//  Brief   : Self-checking bench for seq_restoring_divider (WIDTH=4)
//  Revision: 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_by_zero;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t tbl[10];

    seq_restoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Issue one operation from IDLE, wait for done, check results and latency.
    // Returns the cycle number in which done was seen; ends in the IDLE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic z, input string nm, output int done_cyc);
        int lat;
        bit seen;
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = ~a;
        B = ~b;
        lat = 1;
        seen = 1'b0;
        done_cyc = -1;
        for (int k = 0; k < 12 && !seen; k++) begin
            chk({nm, " busy"}, int'(busy), 1);
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end else begin
                tick();
                lat++;
            end
        end
        chk({nm, " done seen"}, int'(seen), 1);
        chk({nm, " latency"}, lat, (b == '0) ? 1 : W + 1);
        chk({nm, " quot"}, int'(quot), int'(q));
        chk({nm, " rem"}, int'(rem), int'(r));
        chk({nm, " dbz"}, int'(div_by_zero), int'(z));
        tick();
        chk({nm, " done pulse width"}, int'(done), 0);
        chk({nm, " idle"}, int'(busy), 0);
        chk({nm, " quot held"}, int'(quot), int'(q));
    endtask

    initial begin
        int dc;
        int ndone;
        int first_done;
        int prev_dc;
        bit prev_nz;
        logic [W-1:0] eq;
        logic [W-1:0] er;

        tbl[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, z: 1'b0};
        tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
        tbl[2] = '{a: 4'd2,  b: 4'd9,  q: 4'd0,  r: 4'd2, z: 1'b0};
        tbl[3] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
        tbl[4] = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7, z: 1'b1};
        tbl[5] = '{a: 4'd6,  b: 4'd2,  q: 4'd3,  r: 4'd0, z: 1'b0};
        tbl[6] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, z: 1'b0};
        tbl[7] = '{a: 4'd9,  b: 4'd4,  q: 4'd2,  r: 4'd1, z: 1'b0};
        tbl[8] = '{a: 4'd14, b: 4'd5,  q: 4'd2,  r: 4'd4, z: 1'b0};
        tbl[9] = '{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0, z: 1'b1};

        // Reset state
        tick();
        tick();
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset quot", int'(quot), 0);
        chk("reset rem", int'(rem), 0);
        chk("reset dbz", int'(div_by_zero), 0);
        rst = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z,
                   $sformatf("vec%0d", i), dc);
        end

        // start while busy is ignored; only one done, original result
        A = 4'd13;
        B = 4'd3;
        start = 1'b1;
        tick();                 // cycle 1
        start = 1'b0;
        tick();                 // cycle 2
        A = 4'd1;
        B = 4'd1;
        start = 1'b1;
        tick();                 // cycle 3
        start = 1'b0;
        ndone = 0;
        first_done = -1;
        for (int k = 3; k < 14; k++) begin
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
            if (k < 13) tick();
        end
        chk("busy-start done count", ndone, 1);
        chk("busy-start done cycle", first_done, 5);
        chk("busy-start quot", int'(quot), 4);
        chk("busy-start rem", int'(rem), 1);
        chk("busy-start idle", int'(busy), 0);

        // Reset in the middle of CALC
        A = 4'd13;
        B = 4'd3;
        start = 1'b1;
        tick();                 // cycle 1
        start = 1'b0;
        tick();                 // cycle 2
        tick();                 // cycle 3
        rst = 1'b1;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst quot", int'(quot), 0);
        chk("midrst rem", int'(rem), 0);
        chk("midrst done", int'(done), 0);
        tick();
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("midrst no done", ndone, 0);
        run_op(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, "post-rst", dc);

        // Exhaustive sweep at the minimum issue interval
        prev_dc = -1;
        prev_nz = 1'b0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 4'hF;
                    er = W'(a);
                end else begin
                    eq = W'(a / b);
                    er = W'(a % b);
                end
                run_op(W'(a), W'(b), eq, er, (b == 0),
                       $sformatf("sweep %0d/%0d", a, b), dc);
                if (prev_nz && b != 0 && prev_dc >= 0) begin
                    chk($sformatf("spacing %0d/%0d", a, b), dc - prev_dc, W + 2);
                end
                prev_dc = dc;
                prev_nz = (b != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
